// File: rtl/fdtd_jz_source_gen.sv
// fdtd_jz_source_gen
// Replays a host-loaded Jz excitation table, one sample per FDTD time step,
// and holds the cezj coefficient for the downstream Ez source-load stage.
// Samples pass through bit-exact; scaling is done by the downstream multiplier.
//
// Handshake: step_req is a 1-cycle request. It is accepted only in WAIT.
// The sample appears two cycles later with a 1-cycle jz_valid_o strobe.
// A request seen in any other state is dropped and sets the sticky step_ovf_o.
module fdtd_jz_source_gen #(
    parameter int FDTD_DATA_WIDTH = 32,
    parameter int TBL_AW          = 8,
    parameter int STEP_W          = 16
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       cfg_we,
    input  logic [TBL_AW-1:0]          cfg_addr,
    input  logic [FDTD_DATA_WIDTH-1:0] cfg_wdata,
    input  logic [TBL_AW:0]            tbl_len,
    input  logic [STEP_W-1:0]          n_steps,
    input  logic [FDTD_DATA_WIDTH-1:0] cezj_i,
    input  logic                       start,
    input  logic                       step_req,
    output logic [FDTD_DATA_WIDTH-1:0] jz_o,
    output logic                       jz_valid_o,
    output logic [FDTD_DATA_WIDTH-1:0] cezj_o,
    output logic [STEP_W-1:0]          step_idx_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       step_ovf_o,
    output logic [2:0]                 dbg_state_o
);

    localparam int DEPTH = 1 << TBL_AW;
    // Common width for comparing the step counter against the table length.
    localparam int CW = (STEP_W > TBL_AW + 1) ? STEP_W : TBL_AW + 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_READ = 3'd2,
        S_OUT  = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t                     state;
    logic [TBL_AW:0]            tbl_len_q;
    logic [STEP_W-1:0]          n_steps_q;
    logic [STEP_W-1:0]          step_idx;
    logic [FDTD_DATA_WIDTH-1:0] mem [DEPTH];
    logic [FDTD_DATA_WIDTH-1:0] ram_q;
    logic                       in_range;
    logic                       last_step;
    logic                       req_dropped;

    // Steps beyond the loaded table switch the source off.
    assign in_range    = CW'(step_idx) < CW'(tbl_len_q);
    // Compare against n_steps rather than wrapping, so the run always ends.
    assign last_step   = (step_idx + STEP_W'(1)) == n_steps_q;
    assign req_dropped = step_req && (state != S_WAIT);
    assign dbg_state_o = state;

    // Waveform table: host writes only in IDLE, so the table is frozen during a run.
    // Registered read issued when a step request is accepted in WAIT.
    always_ff @(posedge CLK) begin
        if (cfg_we && (state == S_IDLE)) begin
            mem[cfg_addr] <= cfg_wdata;
        end
        if ((state == S_WAIT) && step_req) begin
            ram_q <= mem[step_idx[TBL_AW-1:0]];
        end
    end

    // Run sequencer with registered outputs; strobes default low each cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= S_IDLE;
            tbl_len_q  <= '0;
            n_steps_q  <= '0;
            step_idx   <= '0;
            jz_o       <= '0;
            jz_valid_o <= 1'b0;
            cezj_o     <= '0;
            step_idx_o <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            step_ovf_o <= 1'b0;
        end else begin
            jz_valid_o <= 1'b0;
            done_o     <= 1'b0;
            if (req_dropped) begin
                step_ovf_o <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        tbl_len_q  <= tbl_len;
                        n_steps_q  <= n_steps;
                        cezj_o     <= cezj_i;
                        step_idx   <= '0;
                        step_ovf_o <= 1'b0;
                        if (n_steps == '0) begin
                            state  <= S_FIN;
                            done_o <= 1'b1;
                            busy_o <= 1'b0;
                        end else begin
                            state  <= S_WAIT;
                            busy_o <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (step_req) begin
                        state <= S_READ;
                    end
                end
                S_READ: begin
                    jz_o       <= in_range ? ram_q : '0;
                    jz_valid_o <= 1'b1;
                    step_idx_o <= step_idx;
                    state      <= S_OUT;
                end
                S_OUT: begin
                    step_idx <= step_idx + STEP_W'(1);
                    if (last_step) begin
                        state  <= S_FIN;
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                    end else begin
                        state  <= S_WAIT;
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fdtd_jz_source_gen.sv
// tb_fdtd_jz_source_gen
// Self-checking bench for the Jz source generator. A table-level model
// (array of loaded samples + expected queue per run) predicts each sample.
module tb_fdtd_jz_source_gen;

    logic        CLK;
    logic        RST_N;
    logic        cfg_we;
    logic [7:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [8:0]  tbl_len;
    logic [15:0] n_steps;
    logic [31:0] cezj_i;
    logic        start;
    logic        step_req;
    logic [31:0] jz_o;
    logic        jz_valid_o;
    logic [31:0] cezj_o;
    logic [15:0] step_idx_o;
    logic        busy_o;
    logic        done_o;
    logic        step_ovf_o;
    logic [2:0]  dbg_state_o;

    fdtd_jz_source_gen #(
        .FDTD_DATA_WIDTH(32),
        .TBL_AW(8),
        .STEP_W(16)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .cfg_we(cfg_we),
        .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata),
        .tbl_len(tbl_len),
        .n_steps(n_steps),
        .cezj_i(cezj_i),
        .start(start),
        .step_req(step_req),
        .jz_o(jz_o),
        .jz_valid_o(jz_valid_o),
        .cezj_o(cezj_o),
        .step_idx_o(step_idx_o),
        .busy_o(busy_o),
        .done_o(done_o),
        .step_ovf_o(step_ovf_o),
        .dbg_state_o(dbg_state_o)
    );

    // Clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model state
    logic [31:0] tbl_m [256];
    logic [31:0] exp_q [$];
    logic [31:0] exp_cezj;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          done_cnt = 0;
    int          valid_cnt = 0;

    // Strobe counters, sampled on the falling edge.
    always @(negedge CLK) begin
        if (done_o)     done_cnt++;
        if (jz_valid_o) valid_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_ram(input int addr, input logic [31:0] data, input bit lands);
        cfg_we    = 1'b1;
        cfg_addr  = addr[7:0];
        cfg_wdata = data;
        tick();
        cfg_we = 1'b0;
        if (lands) tbl_m[addr] = data;
    endtask

    // Starts a run and builds the expected sample sequence from the table model.
    task automatic start_run(input int len, input int n, input logic [31:0] cz);
        tbl_len = len[8:0];
        n_steps = n[15:0];
        cezj_i  = cz;
        start   = 1'b1;
        tick();
        start  = 1'b0;
        cfg_we = 1'b0;
        exp_q.delete();
        for (int k = 0; k < n; k++) exp_q.push_back((k < len) ? tbl_m[k] : 32'd0);
        exp_cezj = cz;
    endtask

    // Issues one step request after 'gap' idle cycles; returns what was seen
    // one, two and three cycles after the request.
    task automatic drive_step(input int gap, input bit dbl, output logic early_v,
                              output logic v, output logic [31:0] jz,
                              output logic [15:0] idx, output logic late_v);
        for (int g = 0; g < gap; g++) tick();
        step_req = 1'b1;
        tick();
        early_v = jz_valid_o;
        if (!dbl) step_req = 1'b0;
        tick();
        step_req = 1'b0;
        v   = jz_valid_o;
        jz  = jz_o;
        idx = step_idx_o;
        tick();
        late_v = jz_valid_o;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [86:0] all_o;
        RST_N = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cfg_we = 1'($urandom_range(0, 1)); cfg_addr = 8'($urandom);
            cfg_wdata = $urandom; tbl_len = 9'($urandom); n_steps = 16'($urandom);
            cezj_i = $urandom; start = 1'($urandom_range(0, 1));
            step_req = 1'($urandom_range(0, 1));
            tick();
            all_o = {jz_o, jz_valid_o, cezj_o, step_idx_o, busy_o, done_o, step_ovf_o, dbg_state_o};
            n_checks++;
            if (all_o !== '0) $display("FAIL reset_outputs: got %0h exp 0", all_o); else n_pass++;
        end
        cfg_we = 0; start = 0; step_req = 0; tbl_len = 0; n_steps = 0; cezj_i = 0;
        RST_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({busy_o, done_o, jz_valid_o, step_ovf_o, dbg_state_o} !== 7'd0)
                $display("FAIL post_reset_idle: got busy=%0b done=%0b valid=%0b ovf=%0b st=%0d exp all 0",
                         busy_o, done_o, jz_valid_o, step_ovf_o, dbg_state_o);
            else n_pass++;
        end
    endtask

    task automatic test_basic_run();
        logic ev, v, lv; logic [31:0] jz, e; logic [15:0] idx; int d0;
        write_ram(0, 32'd10, 1); write_ram(1, -32'sd20, 1);
        write_ram(2, 32'd30, 1); write_ram(3, -32'sd40, 1);
        d0 = done_cnt;
        start_run(4, 4, 32'h100);
        n_checks++;
        if (busy_o !== 1'b1 || cezj_o !== 32'h100 || step_ovf_o !== 1'b0)
            $display("FAIL basic_start: got busy=%0b cezj=%0h ovf=%0b exp 1/100/0", busy_o, cezj_o, step_ovf_o);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            drive_step((i == 0) ? 0 : 1, 1'b0, ev, v, jz, idx, lv);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
            n_checks++;
            if (ev !== 1'b0 || v !== 1'b1 || lv !== 1'b0 || jz !== e || idx !== 16'(i) || cezj_o !== 32'h100)
                $display("FAIL basic_sample%0d: got v=%0b%0b%0b jz=%0h idx=%0d cezj=%0h exp v=010 jz=%0h idx=%0d cezj=100",
                         i, ev, v, lv, jz, idx, cezj_o, e, i);
            else n_pass++;
        end
        n_checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b0)
            $display("FAIL basic_done: got done=%0b busy=%0b exp 1/0", done_o, busy_o); else n_pass++;
        tick();
        n_checks++;
        if (done_o !== 1'b0 || jz_o !== -32'sd40 || step_idx_o !== 16'd3 || cezj_o !== 32'h100 || done_cnt - d0 !== 1)
            $display("FAIL basic_hold: got done=%0b jz=%0h idx=%0d cezj=%0h pulses=%0d exp 0/ffffffd8/3/100/1",
                     done_o, jz_o, step_idx_o, cezj_o, done_cnt - d0);
        else n_pass++;
    endtask

    task automatic test_source_off();
        logic ev, v, lv; logic [31:0] jz, e; logic [15:0] idx; int d0;
        write_ram(0, 32'd5, 1); write_ram(1, 32'd6, 1);
        d0 = done_cnt;
        start_run(2, 5, 32'h1234);
        for (int i = 0; i < 5; i++) begin
            drive_step(1, 1'b0, ev, v, jz, idx, lv);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
            n_checks++;
            if (v !== 1'b1 || jz !== e || idx !== 16'(i))
                $display("FAIL srcoff_sample%0d: got v=%0b jz=%0h idx=%0d exp 1 jz=%0h idx=%0d", i, v, jz, idx, e, i);
            else n_pass++;
        end
        tick(); tick();
        n_checks++;
        if (done_cnt - d0 !== 1 || step_ovf_o !== 1'b0)
            $display("FAIL srcoff_end: got pulses=%0d ovf=%0b exp 1/0", done_cnt - d0, step_ovf_o); else n_pass++;
    endtask

    task automatic test_overrun();
        logic ev, v, lv; logic [31:0] jz, e; logic [15:0] idx; int v0;
        v0 = valid_cnt;
        start_run(4, 3, 32'h42);
        drive_step(0, 1'b1, ev, v, jz, idx, lv);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        n_checks++;
        if (v !== 1'b1 || jz !== e || idx !== 16'd0)
            $display("FAIL ovr_sample: got v=%0b jz=%0h idx=%0d exp 1 jz=%0h idx=0", v, jz, idx, e); else n_pass++;
        tick(); tick(); tick();
        n_checks++;
        if (step_ovf_o !== 1'b1 || valid_cnt - v0 !== 1)
            $display("FAIL ovr_flag: got ovf=%0b samples=%0d exp 1/1", step_ovf_o, valid_cnt - v0); else n_pass++;
        for (int i = 1; i < 3; i++) begin
            drive_step(0, 1'b0, ev, v, jz, idx, lv);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
            n_checks++;
            if (v !== 1'b1 || jz !== e || idx !== 16'(i) || step_ovf_o !== 1'b1)
                $display("FAIL ovr_rest%0d: got v=%0b jz=%0h idx=%0d ovf=%0b exp 1 jz=%0h idx=%0d ovf=1",
                         i, v, jz, idx, step_ovf_o, e, i);
            else n_pass++;
        end
        tick();
        start_run(2, 1, 32'h43);
        n_checks++;
        if (step_ovf_o !== 1'b0) $display("FAIL ovr_clear: got ovf=%0b exp 0", step_ovf_o); else n_pass++;
        drive_step(0, 1'b0, ev, v, jz, idx, lv);
        tick();
    endtask

    task automatic test_edge_cases();
        logic ev, v, lv; logic [31:0] jz, e; logic [15:0] idx; int d0, v0;
        // n_steps = 0: a done pulse and no samples.
        d0 = done_cnt; v0 = valid_cnt;
        start_run(3, 0, 32'h55);
        tick(); tick(); tick();
        n_checks++;
        if (done_cnt - d0 !== 1 || valid_cnt - v0 !== 0 || busy_o !== 1'b0 || cezj_o !== 32'h55)
            $display("FAIL zero_steps: got pulses=%0d samples=%0d busy=%0b cezj=%0h exp 1/0/0/55",
                     done_cnt - d0, valid_cnt - v0, busy_o, cezj_o);
        else n_pass++;
        // start while busy is ignored.
        start_run(4, 2, 32'h77);
        drive_step(0, 1'b0, ev, v, jz, idx, lv);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        tbl_len = 9'd0; n_steps = 16'd9; cezj_i = 32'h99; start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (cezj_o !== 32'h77 || busy_o !== 1'b1)
            $display("FAIL busy_start: got cezj=%0h busy=%0b exp 77/1", cezj_o, busy_o); else n_pass++;
        drive_step(0, 1'b0, ev, v, jz, idx, lv);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        n_checks++;
        if (v !== 1'b1 || jz !== e || idx !== 16'd1 || done_o !== 1'b1)
            $display("FAIL busy_start_run: got v=%0b jz=%0h idx=%0d done=%0b exp 1 jz=%0h idx=1 done=1",
                     v, jz, idx, done_o, e);
        else n_pass++;
        tick();
        // cfg_we while busy is dropped.
        start_run(4, 2, 32'h1);
        write_ram(1, 32'hDEAD_BEEF, 0);
        for (int i = 0; i < 2; i++) begin
            drive_step(0, 1'b0, ev, v, jz, idx, lv);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
            n_checks++;
            if (jz !== e) $display("FAIL frozen_tbl%0d: got %0h exp %0h", i, jz, e); else n_pass++;
        end
        tick();
        // Rerun with a write landing in the same cycle as start.
        cfg_we = 1'b1; cfg_addr = 8'd0; cfg_wdata = 32'hCAFE_0001;
        tbl_m[0] = 32'hCAFE_0001;
        start_run(4, 2, 32'h2);
        for (int i = 0; i < 2; i++) begin
            drive_step(0, 1'b0, ev, v, jz, idx, lv);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
            n_checks++;
            if (jz !== e || idx !== 16'(i)) $display("FAIL rerun%0d: got jz=%0h idx=%0d exp jz=%0h idx=%0d", i, jz, idx, e, i);
            else n_pass++;
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        logic ev, v, lv; logic [31:0] jz, e; logic [15:0] idx; int d0;
        logic [86:0] all_o;
        d0 = done_cnt;
        start_run(4, 4, 32'h300);
        drive_step(0, 1'b0, ev, v, jz, idx, lv);
        RST_N = 1'b0;
        #1;
        all_o = {jz_o, jz_valid_o, cezj_o, step_idx_o, busy_o, done_o, step_ovf_o, dbg_state_o};
        n_checks++;
        if (all_o !== '0) $display("FAIL midrun_reset: got %0h exp 0", all_o); else n_pass++;
        tick(); tick();
        RST_N = 1'b1;
        tick(); tick();
        n_checks++;
        if (done_cnt - d0 !== 0 || busy_o !== 1'b0)
            $display("FAIL midrun_nodone: got pulses=%0d busy=%0b exp 0/0", done_cnt - d0, busy_o); else n_pass++;
        start_run(4, 2, 32'h301);
        drive_step(0, 1'b0, ev, v, jz, idx, lv);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        n_checks++;
        if (v !== 1'b1 || jz !== e || idx !== 16'd0)
            $display("FAIL midrun_restart: got v=%0b jz=%0h idx=%0d exp 1 jz=%0h idx=0", v, jz, idx, e); else n_pass++;
        drive_step(0, 1'b0, ev, v, jz, idx, lv);
        tick();
    endtask

    task automatic test_random_runs();
        logic ev, v, lv; logic [31:0] jz, e; logic [15:0] idx; int len, n, d0;
        for (int r = 0; r < 6; r++) begin
            len = (r == 0) ? 0 : $urandom_range(0, 10);
            n   = $urandom_range(1, 12);
            for (int a = 0; a < 12; a++) write_ram(a, $urandom, 1);
            d0 = done_cnt;
            start_run(len, n, $urandom);
            for (int i = 0; i < n; i++) begin
                drive_step($urandom_range(0, 3), 1'b0, ev, v, jz, idx, lv);
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
                n_checks++;
                if (ev !== 1'b0 || v !== 1'b1 || lv !== 1'b0 || jz !== e || idx !== 16'(i) || cezj_o !== exp_cezj)
                    $display("FAIL rand_r%0d_s%0d: got v=%0b%0b%0b jz=%0h idx=%0d cezj=%0h exp v=010 jz=%0h idx=%0d cezj=%0h",
                             r, i, ev, v, lv, jz, idx, cezj_o, e, i, exp_cezj);
                else n_pass++;
            end
            tick();
            n_checks++;
            if (done_cnt - d0 !== 1 || step_ovf_o !== 1'b0 || busy_o !== 1'b0)
                $display("FAIL rand_end_r%0d: got pulses=%0d ovf=%0b busy=%0b exp 1/0/0",
                         r, done_cnt - d0, step_ovf_o, busy_o);
            else n_pass++;
        end
    endtask

    initial begin
        RST_N = 1'b0; cfg_we = 0; cfg_addr = 0; cfg_wdata = 0; tbl_len = 0;
        n_steps = 0; cezj_i = 0; start = 0; step_req = 0;
        for (int a = 0; a < 256; a++) tbl_m[a] = 32'd0;
        test_reset();
        test_basic_run();
        test_source_off();
        test_overrun();
        test_edge_cases();
        test_reset_mid_run();
        test_random_runs();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
